// File: rtl/uart_rx_os.sv
// UART receiver driven by a 16x oversampling tick source.
// Recovers LSB-first frames with 3-sample majority voting per bit and
// holds each byte for the host with valid/read handshake, framing-error
// and sticky overrun flags. Everything runs on sys_clk; baud_clk is only
// edge-detected into a one-cycle tick.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_l,
  input  logic                 baud_clk,
  input  logic                 rx_in,
  input  logic                 rx_rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int TC_W = $clog2(OVERSAMPLE);
  localparam int BI_W = $clog2(DATA_BITS);

  // Sample points straddle the bit centre; the period ends on the last tick.
  localparam logic [TC_W-1:0] TC_S0  = TC_W'(OVERSAMPLE/2 - 1);
  localparam logic [TC_W-1:0] TC_S1  = TC_W'(OVERSAMPLE/2);
  localparam logic [TC_W-1:0] TC_S2  = TC_W'(OVERSAMPLE/2 + 1);
  localparam logic [TC_W-1:0] TC_END = TC_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                state;
  logic                  baud_q;
  logic                  rx_meta;
  logic                  rx_s;
  logic                  rx_s_q;
  logic                  tick;
  logic                  fall;
  logic                  maj;
  logic [TC_W-1:0]       tc;
  logic [BI_W-1:0]       bit_idx;
  logic [1:0]            smp;
  logic [DATA_BITS-1:0]  shreg;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Front end: baud_clk edge register, 2-flop synchroniser, rx edge register.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      baud_q  <= 1'b0;
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      baud_q  <= baud_clk;
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_s_q  <= rx_s;
    end
  end

  assign tick    = baud_clk & ~baud_q;
  assign fall    = rx_s_q & ~rx_s;
  // Third sample is the live synchronised line on the TC_S2 tick.
  assign maj     = majority3(smp[0], smp[1], rx_s);
  assign rx_busy = (state != IDLE);

  // Receive FSM with the host-side holding registers.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state        <= IDLE;
      tc           <= '0;
      bit_idx      <= '0;
      smp          <= 2'b00;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      // A read consumes the held byte; a completion later in this block
      // overrides these clears so completion wins a same-cycle collision.
      if (rx_rd && rx_valid) begin
        rx_valid     <= 1'b0;
        rx_frame_err <= 1'b0;
        rx_overrun   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fall) begin
            tc      <= '0;
            bit_idx <= '0;
            state   <= START;
          end
        end

        START, DATA, STOP: begin
          if (tick) begin
            tc <= (tc == TC_END) ? '0 : tc + 1'b1;
            if (tc == TC_S0) smp[0] <= rx_s;
            if (tc == TC_S1) smp[1] <= rx_s;

            if (tc == TC_S2) begin
              if (state == START) begin
                // Line back high at mid-bit: treat as a glitch, not a frame.
                if (maj) state <= IDLE;
              end else if (state == DATA) begin
                shreg <= {maj, shreg[DATA_BITS-1:1]};
              end else begin
                // Stop bit decided: hand the byte over without waiting
                // for the rest of the period.
                rx_data      <= shreg;
                rx_frame_err <= ~maj;
                rx_valid     <= 1'b1;
                if (rx_valid && !rx_rd) rx_overrun <= 1'b1;
                state        <= maj ? IDLE : WAIT_HIGH;
              end
            end

            if (tc == TC_END) begin
              if (state == START) begin
                state   <= DATA;
                bit_idx <= '0;
              end else if (state == DATA) begin
                if (bit_idx == BI_LAST) state <= STOP;
                else                    bit_idx <= bit_idx + 1'b1;
              end
            end
          end
        end

        WAIT_HIGH: begin
          // A held-low line (break) must not look like a new start bit.
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: a table of frames with expected host-side
// results, plus hand-written start-glitch and mid-frame-reset sequences.
// baud_clk rises every 4 sys_clk cycles, so one bit lasts 16 ticks.
module tb_uart_rx_os;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_l = 1'b0;
  logic       baud_clk  = 1'b0;
  logic       rx_in     = 1'b1;
  logic       rx_rd     = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] bcnt = 2'd0;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       stop;
    int         hold_low;   // extra bit times the line stays low after the stop bit
    int         gbit;       // frame bit to glitch (0 = start), -1 for none
    int         gfirst;     // first tick of the glitch within that bit
    int         glast;      // last tick of the glitch within that bit
    logic       rd;         // pulse rx_rd after checking
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[7];

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_l    (sys_rst_l),
    .baud_clk     (baud_clk),
    .rx_in        (rx_in),
    .rx_rd        (rx_rd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  // 16x baud clock: high 2 cycles, low 2 cycles, changing on sys_clk edges.
  always @(posedge sys_clk) begin
    bcnt     <= bcnt + 2'd1;
    baud_clk <= bcnt[1];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge baud_clk);
  endtask

  // Drive start, 8 data bits LSB first, stop; optionally invert one bit
  // over a tick window to emulate a glitch.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int gbit, input int gfirst, input int glast);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int t = 0; t < 16; t++) begin
        rx_in = fr[b] ^ ((b == gbit) && (t >= gfirst) && (t <= glast));
        @(posedge baud_clk);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    send_frame(v.data, v.stop, v.gbit, v.gfirst, v.glast);
    if (v.hold_low > 0) begin
      wait_ticks(16 * v.hold_low);
      @(negedge sys_clk);
      check({v.name, "_busy_wait_high"}, {31'd0, rx_busy}, 32'd1);
      rx_in = 1'b1;
    end
    wait_ticks(4);
    @(negedge sys_clk);
    check({v.name, "_data"},  {24'd0, rx_data},      {24'd0, v.exp_data});
    check({v.name, "_valid"}, {31'd0, rx_valid},     {31'd0, v.exp_valid});
    check({v.name, "_ferr"},  {31'd0, rx_frame_err}, {31'd0, v.exp_ferr});
    check({v.name, "_ovr"},   {31'd0, rx_overrun},   {31'd0, v.exp_ovr});
    check({v.name, "_busy"},  {31'd0, rx_busy},      32'd0);
    if (v.rd) begin
      rx_rd = 1'b1;
      @(negedge sys_clk);
      rx_rd = 1'b0;
      @(negedge sys_clk);
      check({v.name, "_rd_valid"}, {31'd0, rx_valid},     32'd0);
      check({v.name, "_rd_ferr"},  {31'd0, rx_frame_err}, 32'd0);
      check({v.name, "_rd_ovr"},   {31'd0, rx_overrun},   32'd0);
      check({v.name, "_rd_data"},  {24'd0, rx_data},      {24'd0, v.exp_data});
    end
  endtask

  initial begin
    vec_t v3c;
    vec_t v81;

    //            name          data   stop  hold gbit gf gl  rd    exp    vld   ferr  ovr
    vecs[0] = '{"a5_basic",   8'hA5, 1'b1, 0,  -1, 0, 0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"5a_ferr",    8'h5A, 1'b0, 2,  -1, 0, 0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{"01_after",   8'h01, 1'b1, 0,  -1, 0, 0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"11_first",   8'h11, 1'b1, 0,  -1, 0, 0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"22_overrun", 8'h22, 1'b1, 0,  -1, 0, 0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{"glitch_1",   8'h00, 1'b1, 0,   4, 8, 8, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"glitch_3",   8'h00, 1'b1, 0,   4, 7, 9, 1'b1, 8'h08, 1'b1, 1'b0, 1'b0};
    v3c     = '{"3c_post",    8'h3C, 1'b1, 0,  -1, 0, 0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    v81     = '{"81_post",    8'h81, 1'b1, 0,  -1, 0, 0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_data",  {24'd0, rx_data},      32'd0);
    check("rst_valid", {31'd0, rx_valid},     32'd0);
    check("rst_ferr",  {31'd0, rx_frame_err}, 32'd0);
    check("rst_ovr",   {31'd0, rx_overrun},   32'd0);
    check("rst_busy",  {31'd0, rx_busy},      32'd0);
    sys_rst_l = 1'b1;
    wait_ticks(4);

    // Start-bit glitch: 4 ticks low must be rejected at mid-bit
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    @(negedge sys_clk);
    check("sglitch_busy_hi", {31'd0, rx_busy}, 32'd1);
    wait_ticks(10);
    @(negedge sys_clk);
    check("sglitch_busy_lo", {31'd0, rx_busy},  32'd0);
    check("sglitch_valid",   {31'd0, rx_valid}, 32'd0);
    wait_ticks(4);
    run_vec(v3c);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      wait_ticks(2);
    end

    // Reset during data bit 4 of 0xFF
    rx_in = 1'b0;
    wait_ticks(16);
    rx_in = 1'b1;
    wait_ticks(64 + 8);
    @(negedge sys_clk);
    check("abort_busy_pre", {31'd0, rx_busy}, 32'd1);
    sys_rst_l = 1'b0;
    @(negedge sys_clk);
    check("abort_rst_busy",  {31'd0, rx_busy},  32'd0);
    check("abort_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("abort_rst_data",  {24'd0, rx_data},  32'd0);
    @(negedge sys_clk);
    sys_rst_l = 1'b1;
    wait_ticks(8 + 48 + 16 + 4);
    @(negedge sys_clk);
    check("abort_busy",  {31'd0, rx_busy},  32'd0);
    check("abort_valid", {31'd0, rx_valid}, 32'd0);
    check("abort_data",  {24'd0, rx_data},  32'd0);
    run_vec(v81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- UART receiver that consumes the 16x-oversampled baud_clk produced by the baud-rate generator. Runs entirely on sys_clk and treats baud_clk as a tick source, not as a clock.
- Recovers 8N1 (parameterisable data width) serial frames from the asynchronous rx_in line, using 3-sample majority voting per bit.
- Holds each received byte for the host interface with a valid/read handshake, plus framing-error and overrun flags.

Parameters:
- DATA_BITS, 8, number of data bits per frame (LSB first), 5..9.
- OVERSAMPLE, 16, baud_clk ticks per bit; must match the generator; even, >= 8.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_l  in  1  asynchronous active-low reset.
- baud_clk  in  1  16x baud clock from the generator; synchronous to sys_clk, toggles on sys_clk edges.
- rx_in  in  1  asynchronous serial line, idle high.
- rx_rd  in  1  one-cycle read strobe; consumes the held byte.
- rx_data  out  DATA_BITS  last received data.
- rx_valid  out  1  level: unread data held in rx_data.
- rx_frame_err  out  1  stop bit of the held byte sampled low.
- rx_overrun  out  1  sticky: a byte completed while rx_valid=1.
- rx_busy  out  1  frame reception in progress (state != IDLE).

Behaviour:
- Reset: the interface is as stated: reset sys_rst_l, asynchronous, active-low; clock sys_clk. All outputs 0, rx_data=0, state IDLE. The synchroniser flops and the rx edge register reset to 1 (line idle).
- Tick: one register on baud_clk. tick = baud_clk & ~baud_clk_q, i.e. one sys_clk pulse per baud_clk rising edge. All bit timing counts ticks only.
- rx_in passes through a 2-flop synchroniser to give rx_s. There is no other filtering.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - On the falling edge of rx_s (1 to 0), clear the tick counter tc and go to START. This does not wait for a tick.
- Bit sampling, common to START/DATA/STOP:
  - tc increments on each tick, 0..OVERSAMPLE-1.
  - rx_s is captured on ticks where tc = OVERSAMPLE/2-1, OVERSAMPLE/2, and OVERSAMPLE/2+1 (7, 8, 9 at the default).
  - The bit value is the majority of the 3 samples.
  - The bit period ends on the tick where tc = OVERSAMPLE-1; tc then wraps to 0.
- START:
  - Majority 1 (false start or glitch): return to IDLE immediately after the third sample. Nothing is flagged.
  - Majority 0: at the end of the period go to DATA with bit index 0.
- DATA:
  - The majority value shifts into the shift register LSB-first.
  - After DATA_BITS periods, go to STOP.
- STOP: complete the frame on the tick that takes the third sample. Do not wait for the end of the period. On completion:
  - rx_data <= shift register on the next sys_clk.
  - rx_frame_err <= ~majority.
  - rx_valid <= 1.
  - If rx_valid was already 1 and no rx_rd in the same cycle, rx_overrun <= 1. The new data overwrites the old.
  - Next state: IDLE if majority = 1, otherwise WAIT_HIGH.
- WAIT_HIGH (break or framing error): stay until rx_s = 1, then go to IDLE. This prevents a held-low line from restarting reception.
- rx_rd:
  - Clears rx_valid, rx_frame_err and rx_overrun on the next sys_clk.
  - rx_rd with rx_valid=0 has no effect.
  - rx_rd in the same cycle as completion: completion wins. rx_valid stays 1, rx_data is updated, and overrun is not set.
- Latency: rx_valid rises 1 sys_clk after the stop bit's 3rd sample tick, i.e. about 9.5/16 bit into the stop bit.
- rx_busy = (state != IDLE).
- Reset mid-frame: return to IDLE immediately and discard the partial byte. The first falling edge after release starts a new frame.
- baud_clk stalled: the FSM holds its state. There is no timeout.

Test Plan:
- Send 0xA5 8N1 at the generator's rate, rx_rd held 0 -> rx_data=0xA5, rx_valid=1, rx_frame_err=0, rx_overrun=0; rx_rd pulse -> rx_valid=0 next cycle.
- rx_in low for 4 ticks then high (start glitch) -> no rx_valid, rx_busy returns to 0 before tick 10; a following 0x3C frame is received correctly.
- Frame 0x5A with the stop bit driven low, then line high after 2 bit times -> rx_data=0x5A, rx_valid=1, rx_frame_err=1; state passes through WAIT_HIGH; the next frame 0x01 is received correctly.
- Two frames 0x11 then 0x22 with no rx_rd -> rx_data=0x22, rx_overrun=1; rx_rd clears all three flags.
- Data bit 3 of 0x00 driven high only at tick 8 (single-sample glitch) -> rx_data=0x00; driven high at ticks 7-9 -> rx_data=0x08.
- Assert sys_rst_l=0 during data bit 4 of 0xFF, release, then send 0x81 -> no output from the aborted frame; rx_data=0x81, rx_valid=1.
